// File: rtl/csla_seq_ctrl_if.sv
// Start/done request bus for csla_seq_ctrl; master drives the request, slave returns the result.
// The sub port exists only when CSLA_SEQ_SUB_EN is defined.
interface csla_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CSLA_SEQ_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef CSLA_SEQ_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/csla_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit carry-select slice, one nibble per clock, LSB first.
// Optional macro CSLA_SEQ_SUB_EN adds a sub input that turns the operation into a - b.
module csla_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    csla_seq_ctrl_if.slave       bus
);
    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic              w_busy;
    logic              w_done;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    logic [WIDTH-1:0]  w_bIn;
    logic              w_cIn;
    logic [IDXW+1:0]   w_bitOff;
    logic [3:0]        w_aNib;
    logic [3:0]        w_bNib;
    logic [4:0]        w_path0;
    logic [4:0]        w_path1;
    logic [4:0]        w_sel;
    logic              w_last;
    logic [WIDTH-1:0]  w_accNext;

    // Subtraction is a + ~b + 1, so the operand and carry are rewritten at capture time.
`ifdef CSLA_SEQ_SUB_EN
    assign w_bIn = bus.sub ? ~bus.b : bus.b;
    assign w_cIn = bus.sub ? 1'b1   : bus.cin;
`else
    assign w_bIn = bus.b;
    assign w_cIn = bus.cin;
`endif

    assign w_bitOff = {r_idx, 2'b00};
    assign w_aNib   = r_a[w_bitOff +: 4];
    assign w_bNib   = r_b[w_bitOff +: 4];

    // Both carry-in cases are computed up front; the registered carry only picks one.
    assign w_path0  = {1'b0, w_aNib} + {1'b0, w_bNib};
    assign w_path1  = {1'b0, w_aNib} + {1'b0, w_bNib} + 5'd1;
    assign w_sel    = r_carry ? w_path1 : w_path0;
    assign w_last   = (r_idx == IDXW'(N - 1));

    always_comb begin
        w_accNext = r_acc;
        w_accNext[w_bitOff +: 4] = w_sel[3:0];
    end

    always_comb begin
        w_stateNext = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_stateNext = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= w_bIn;
                        r_carry <= w_cIn;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_accNext;
                    r_carry <= w_sel[4];
                    // The index stops at the last nibble rather than wrapping.
                    if (w_last) begin
                        r_sum  <= w_accNext;
                        r_cout <= w_sel[4];
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_csla_seq_ctrl.sv
// Scoreboard bench for csla_seq_ctrl: a 16-bit and a 4-bit instance share clock and reset.
// Directed vectors push expected results; a negedge monitor pops them whenever done is seen.
module tb_csla_seq_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      int          doneCyc;
   } exp_t;

   exp_t q16[$];
   exp_t q4[$];

   csla_seq_ctrl_if #(.WIDTH(16)) bus16();
   csla_seq_ctrl_if #(.WIDTH(4))  bus4();

   csla_seq_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
   csla_seq_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (bus16.done === 1'b1) begin
         if (q16.size() == 0) begin
            checkOutput("unexpectedDone16", 32'd1, 32'd0);
         end else begin
            e = q16.pop_front();
            checkOutput("sum16", 32'(bus16.sum), 32'(e.sum));
            checkOutput("cout16", 32'(bus16.cout), 32'(e.cout));
            checkOutput("doneCycle16", 32'(cyc), 32'(e.doneCyc));
         end
      end
      if (bus4.done === 1'b1) begin
         if (q4.size() == 0) begin
            checkOutput("unexpectedDone4", 32'd1, 32'd0);
         end else begin
            e = q4.pop_front();
            checkOutput("sum4", 32'(bus4.sum), 32'(e.sum));
            checkOutput("cout4", 32'(bus4.cout), 32'(e.cout));
            checkOutput("doneCycle4", 32'(cyc), 32'(e.doneCyc));
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one start pulse on the 16-bit bus; called 1 time unit after a rising edge.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                input logic sub, input logic [15:0] expSum, input logic expCout,
                                input bit expectAccept);
      exp_t e;
      bus16.start = 1'b1;
      bus16.a     = a;
      bus16.b     = b;
      bus16.cin   = cin;
`ifdef CSLA_SEQ_SUB_EN
      bus16.sub   = sub;
`else
      if (sub) $display("[TB] sub requested but feature not built");
`endif
      if (expectAccept) begin
         e.sum     = expSum;
         e.cout    = expCout;
         e.doneCyc = cyc + 5;
         q16.push_back(e);
      end
      waitCycles(1);
      bus16.start = 1'b0;
      bus16.a     = 16'hDEAD;
      bus16.b     = 16'hBEEF;
   endtask

   task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                                 input logic [3:0] expSum, input logic expCout);
      exp_t e;
      bus4.start = 1'b1;
      bus4.a     = a;
      bus4.b     = b;
      bus4.cin   = cin;
      e.sum      = 16'(expSum);
      e.cout     = expCout;
      e.doneCyc  = cyc + 2;
      q4.push_back(e);
      waitCycles(1);
      bus4.start = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      rst = 1'b1;
      bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
      bus4.start  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0;
`ifdef CSLA_SEQ_SUB_EN
      bus16.sub = 1'b0;
      bus4.sub  = 1'b0;
`endif
      waitCycles(2);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("resetBusy", 32'(bus16.busy), 32'd0);
      checkOutput("resetDone", 32'(bus16.done), 32'd0);
      checkOutput("resetSum", 32'(bus16.sum), 32'd0);
      checkOutput("resetCout", 32'(bus16.cout), 32'd0);
      waitCycles(1);

      $display("[TB] full carry propagation");
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         checkOutput($sformatf("busyCycle%0d", i), 32'(bus16.busy), (i <= 5) ? 32'd1 : 32'd0);
         waitCycles(1);
      end

      $display("[TB] carry-in used, outputs held");
      applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b1);
      waitCycles(5);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("heldSum", 32'(bus16.sum), 32'h5556);
         checkOutput("heldCout", 32'(bus16.cout), 32'd0);
         waitCycles(1);
      end

      $display("[TB] busy rejection and back-to-back");
      applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);
      waitCycles(1);
      applyStimulus(16'hAAAA, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      waitCycles(2);
      applyStimulus(16'hAAAA, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      applyStimulus(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
      waitCycles(7);

      $display("[TB] reset mid-operation");
      applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("midOpBusy", 32'(bus16.busy), 32'd1);
      waitCycles(2);
      rst = 1'b1;
      waitCycles(1);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postRstBusy", 32'(bus16.busy), 32'd0);
      checkOutput("postRstDone", 32'(bus16.done), 32'd0);
      checkOutput("postRstSum", 32'(bus16.sum), 32'd0);
      checkOutput("postRstCout", 32'(bus16.cout), 32'd0);
      waitCycles(8);
      applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b1);
      waitCycles(6);

`ifdef CSLA_SEQ_SUB_EN
      $display("[TB] subtraction");
      applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1);
      waitCycles(6);
      applyStimulus(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b1);
      waitCycles(6);
      applyStimulus(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b1);
      waitCycles(6);
`endif

      $display("[TB] minimum width");
      applyStimulus4(4'h9, 4'h8, 1'b1, 4'h2, 1'b1);
      waitCycles(3);
      applyStimulus4(4'hF, 4'h0, 1'b1, 4'h0, 1'b1);
      waitCycles(3);
      applyStimulus4(4'h3, 4'h4, 1'b0, 4'h7, 1'b0);
      waitCycles(3);

      guard = 0;
      while ((q16.size() != 0 || q4.size() != 0) && guard < 50) begin
         waitCycles(1);
         guard++;
      end
      if (q16.size() != 0) checkOutput("pending16", 32'(q16.size()), 32'd0);
      if (q4.size() != 0) checkOutput("pending4", 32'(q4.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/csla_seq_ctrl.md
Name: csla_seq_ctrl

Overview:
- Multi-cycle wide-adder controller. Adds two WIDTH-bit operands using one internal 4-bit carry-select slice, processing one nibble per clock from LSB to MSB.
- The slice precomputes two ripple paths, one with carry-in 0 and one with carry-in 1. The registered inter-nibble carry selects between them.
- Sits between a requester using a start/done handshake and downstream logic. Lets datapaths reuse a single slice instead of instantiating a full-width adder.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and at least 4; other values are illegal, with no run-time check. N = WIDTH/4 nibbles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result; held until next result
- cout  output  1  registered final carry-out; held with sum

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - On rst: state=IDLE, busy=0, done=0, sum=0, cout=0, nibble index=0, carry reg=0, operand regs=0.
  - rst has priority over every other event, including mid-RUN. An in-flight operation is discarded; no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch a, b, cin (carry reg<=cin), idx<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN (one nibble per cycle):
  - Slice inputs: a_reg[4*idx+:4], b_reg[4*idx+:4].
  - Nibble result = carry reg ? path1 : path0. Write it into the result accumulator at bits [4*idx+:4].
  - carry reg <= selected nibble carry-out; idx <= idx+1.
  - When idx==N-1: load the sum output reg from the completed accumulator, load cout from the final carry, go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy=1. Go to IDLE.
  - start is ignored in DONE.
- Timing:
  - start accepted in cycle 0 → RUN occupies cycles 1..N → done=1 in cycle N+1.
  - sum/cout change on the same edge that raises done.
  - Earliest next accepted start is in cycle N+2 (IDLE). Throughput is one operation per N+2 cycles.
- Handshake rules:
  - start while busy=1 is dropped, not queued. Operand inputs are don't-care except in the cycle start is accepted.
  - sum/cout are stable from done until the DONE edge of the next operation.
  - For WIDTH=4 (N=1): RUN lasts one cycle, done in cycle 2.
- Arithmetic:
  - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), exact.
  - No overflow flag. idx width is clog2(N), minimum 1 bit. idx never wraps past N-1.

Optional Feature:
- Macro: CSLA_SEQ_SUB_EN.
- Defined:
  - Adds port sub (input, 1), captured with start.
  - If sub=1: the B register latches ~b and carry reg latches 1, ignoring cin. Result is a−b.
  - cout=1 means no borrow (a≥b unsigned).
  - If sub=0: behaviour is identical to the base block.
- Not defined: no sub port; addition only.

Test Plan (WIDTH=16 unless noted):
- Full carry propagation.
  - Stimulus: rst for 2 cycles, then start with a=0xFFFF, b=0x0001, cin=0.
  - Response: busy=1 in cycles 1–5; done=1 only in cycle 5; sum=0x0000, cout=1.
- Carry-in used, no carry-out.
  - Stimulus: a=0x1234, b=0x4321, cin=1.
  - Response: done at cycle 5; sum=0x5556, cout=0. Outputs stay held for 10 idle cycles after done.
- Busy rejection and back-to-back.
  - Stimulus: start 0x00FF+0x0001 accepted; start pulses in cycles 2 and 5 carrying a=0xAAAA.
  - Response: result 0x0100, cout=0, with no second done. A start in cycle 6 is accepted and gives done in cycle 11.
- Reset mid-operation.
  - Stimulus: start 0x8000+0x8000; rst=1 in cycle 3.
  - Response: next cycle busy=0, done=0, sum=0, cout=0; no done pulse ever follows. A new start works normally afterwards.
- Minimum width (WIDTH=4).
  - Stimulus: a=0x9, b=0x8, cin=1.
  - Response: done in cycle 2; sum=0x2, cout=1.
- With CSLA_SEQ_SUB_EN.
  - Stimulus 1: a=0x0005, b=0x0007, sub=1. Response: sum=0xFFFE, cout=0.
  - Stimulus 2: a=0x0007, b=0x0005, sub=1. Response: sum=0x0002, cout=1.
